// File: rtl/bcd_pkg.sv
// Shared definitions for the single-digit BCD counter.
package bcd_pkg;
  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  // Any non-BCD code (10-15) is forced to zero so the digit never leaves 0-9.
  function automatic bcd_t bcd_sanitize(input bcd_t v);
    return (v > BCD_MAX) ? BCD_ZERO : v;
  endfunction
endpackage

// File: rtl/bcd_digit_next.sv
// Combinational decimal successor of one BCD digit, with terminal-count wrap flag.
module bcd_digit_next
  import bcd_pkg::*;
(
  input  bcd_t digit_i,
  input  logic inc_i,
  output bcd_t next_o,
  output logic wrap_o
);

  always_comb begin
    wrap_o = inc_i && (digit_i == BCD_MAX);
    next_o = digit_i;
    if (wrap_o) begin
      next_o = BCD_ZERO;
    end else if (inc_i) begin
      next_o = digit_i + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_cnt.sv
// Single-digit synchronous BCD counter with parallel load and count enable.
// Define BCDCNT_CARRY_EN to add the combinational CARRY output for cascading digits.
module bcd_cnt
  import bcd_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic LOAD,
  input  bcd_t DATA,
  input  logic INC,
`ifdef BCDCNT_CARRY_EN
  output logic CARRY,
`endif
  output bcd_t COUNT
);

  bcd_t count_q;
  bcd_t count_d;
  bcd_t digit_nxt;
  logic wrap;

  bcd_digit_next u_next (
    .digit_i (count_q),
    .inc_i   (INC),
    .next_o  (digit_nxt),
    .wrap_o  (wrap)
  );

  // Priority: RESET > LOAD > INC > hold.
  always_comb begin
    count_d = count_q;
    if (RESET) begin
      count_d = BCD_ZERO;
    end else if (LOAD) begin
      count_d = bcd_sanitize(DATA);
    end else if (wrap) begin
      count_d = BCD_ZERO;
    end else begin
      count_d = digit_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    count_q <= count_d;
  end

  assign COUNT = count_q;

`ifdef BCDCNT_CARRY_EN
  assign CARRY = wrap & ~LOAD & ~RESET;
`endif

endmodule

// File: tb/tb_bcd_cnt.sv
// Self-checking bench for bcd_cnt: directed vector table followed by randomized traffic.
module tb_bcd_cnt;
  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       LOAD = 1'b0;
  logic [3:0] DATA = 4'd0;
  logic       INC = 1'b0;
  logic [3:0] COUNT;
`ifdef BCDCNT_CARRY_EN
  logic       CARRY;
`endif

  bcd_cnt dut (
    .CLK   (CLK),
    .RESET (RESET),
    .LOAD  (LOAD),
    .DATA  (DATA),
    .INC   (INC),
`ifdef BCDCNT_CARRY_EN
    .CARRY (CARRY),
`endif
    .COUNT (COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] data;
    logic       inc;
    logic [3:0] exp_count;
    logic       exp_carry;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic add(input logic r, input logic l, input logic [3:0] d,
                     input logic i, input logic [3:0] ec, input logic ey);
    vec_t v;
    v.rst = r; v.load = l; v.data = d; v.inc = i;
    v.exp_count = ec; v.exp_carry = ey;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, check carry before the edge, count after it.
  task automatic apply(input string name, input logic r, input logic l,
                       input logic [3:0] d, input logic i,
                       input logic [3:0] ec, input logic ey);
    logic [3:0] want;
    @(negedge CLK);
    RESET = r; LOAD = l; DATA = d; INC = i;
    exp_q.push_back(ec);
`ifdef BCDCNT_CARRY_EN
    #1;
    n_cmp++;
    if (CARRY !== ey) begin
      n_bad++;
      $display("FAIL %s carry: got %b want %b", name, CARRY, ey);
    end
`else
    if (ey === 1'bx) $display("note: unexpected x carry");
`endif
    @(posedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s scoreboard: empty queue, count got %0d", name, COUNT);
    end else begin
      want = exp_q.pop_front();
      if (COUNT !== want) begin
        n_bad++;
        $display("FAIL %s count: got %0d want %0d", name, COUNT, want);
      end
    end
  endtask

  function automatic logic [3:0] model_next(input logic [3:0] cur, input logic r,
                                            input logic l, input logic [3:0] d,
                                            input logic i);
    if (r) return 4'd0;
    if (l) return (d <= 4'd9) ? d : 4'd0;
    if (i) return (cur == 4'd9) ? 4'd0 : cur + 4'd1;
    return cur;
  endfunction

  initial begin
    logic [3:0] cur;
    logic       r, l, i, cy;
    logic [3:0] d, nx;

    // reset with INC active, then count
    add(1, 0, 4'd8, 1, 4'd0, 0);
    add(0, 0, 4'd0, 1, 4'd1, 0);
    add(0, 0, 4'd0, 1, 4'd2, 0);
    add(0, 0, 4'd0, 1, 4'd3, 0);
    // load over increment, then wrap
    add(0, 1, 4'd8, 1, 4'd8, 0);
    add(0, 0, 4'd8, 1, 4'd9, 0);
    add(0, 0, 4'd8, 1, 4'd0, 1);
    add(0, 0, 4'd8, 1, 4'd1, 0);
    add(0, 0, 4'd8, 1, 4'd2, 0);
    add(0, 0, 4'd8, 1, 4'd3, 0);
    // hold, load while idle, hold
    for (int k = 0; k < 5; k++) add(0, 0, 4'd2, 0, 4'd3, 0);
    add(0, 1, 4'd2, 0, 4'd2, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 4'd2, 0, 4'd2, 0);
    // reset priority over everything
    add(1, 1, 4'd6, 1, 4'd0, 0);
    add(0, 0, 4'd6, 1, 4'd1, 0);
    // invalid loads and load of terminal value
    add(0, 1, 4'd12, 0, 4'd0, 0);
    add(0, 1, 4'd9, 0, 4'd9, 0);
    add(0, 0, 4'd9, 1, 4'd0, 1);
    add(0, 1, 4'd9, 0, 4'd9, 0);
    add(0, 1, 4'd4, 1, 4'd4, 0);
    add(0, 1, 4'd9, 0, 4'd9, 0);
    add(1, 0, 4'd0, 1, 4'd0, 0);
    add(0, 1, 4'd5, 0, 4'd5, 0);
    add(0, 1, 4'd15, 1, 4'd0, 0);
    add(0, 1, 4'd10, 0, 4'd0, 0);
    add(0, 0, 4'd7, 0, 4'd0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      apply($sformatf("vec%0d", k), tbl[k].rst, tbl[k].load, tbl[k].data,
            tbl[k].inc, tbl[k].exp_count, tbl[k].exp_carry);
    end

    // randomized traffic against a reference model
    cur = 4'd0;
    for (int k = 0; k < 200; k++) begin
      r  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 5) == 0);
      i  = ($urandom_range(0, 3) != 0);
      d  = 4'($urandom_range(0, 15));
      cy = i && !l && !r && (cur == 4'd9);
      nx = model_next(cur, r, l, d, i);
      apply($sformatf("rnd%0d", k), r, l, d, i, nx, cy);
      cur = nx;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
